fixed_tile_replay_buffer: RTL and testbench

- Producer-side feeder for the fixed-point matmul/linear cores.
- Captures one weight column-block of DEPTH tiles from an upstream valid/ready stream, then replays it REPEAT times in order.
- Weights are reused across every row-block of the data operand without refetching from upstream.
- Output port matches the weight input of the matmul core: unpacked array of TILE_ROWS*TILE_COLUMNS elements with valid/ready.

---
 rtl/fixed_tile_replay_buffer_pkg.sv | 11 +
 rtl/fixed_tile_replay_buffer_if.sv | 23 ++
 rtl/fixed_tile_replay_buffer_counter.sv | 35 +++
 rtl/fixed_tile_replay_buffer.sv | 109 ++++++++++
 tb/tb_fixed_tile_replay_buffer.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fixed_tile_replay_buffer_pkg.sv
// Shared types and helpers for the fixed-point tile replay buffer.
package fixed_tile_pkg;

    typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} tile_replay_state_t;

    // Counter width for a modulo-n counter, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fixed_tile_replay_buffer_if.sv
// Tile stream bundle: upstream capture side and downstream replay side.
interface fixed_tile_replay_buffer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int N_ELEM     = 15
);
    logic [DATA_WIDTH-1:0] data_in  [N_ELEM];
    logic                  data_in_valid;
    logic                  data_in_ready;
    logic [DATA_WIDTH-1:0] data_out [N_ELEM];
    logic                  data_out_valid;
    logic                  data_out_ready;
    logic                  data_out_last;

    modport slave (
        input  data_in, data_in_valid, data_out_ready,
        output data_in_ready, data_out, data_out_valid, data_out_last
    );

    modport master (
        output data_in, data_in_valid, data_out_ready,
        input  data_in_ready, data_out, data_out_valid, data_out_last
    );
endinterface

// File: rtl/fixed_tile_replay_buffer_counter.sv
// Modulo-N counter with increment enable, synchronous clear and a wrap pulse.
module tile_wrap_counter
    import fixed_tile_pkg::*;
#(
    parameter int N = 4,
    parameter int W = cnt_w(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);
    localparam logic [W-1:0] MAX = W'(N - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign wrap_o = inc_i && (cnt_q == MAX);
    assign cnt_o  = cnt_q;

    // Next count: clear wins, then wrap to zero, then plain increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)       cnt_d = '0;
        else if (wrap_o) cnt_d = '0;
        else if (inc_i)  cnt_d = cnt_q + W'(1);
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/fixed_tile_replay_buffer.sv
// Captures DEPTH tiles, then replays them REPEAT times in order.
// Optional macro TILE_REPLAY_PASSTHROUGH_EN: tiles are forwarded while being
// captured, and that forwarded stream counts as the first pass.
module fixed_tile_replay_buffer
    import fixed_tile_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int TILE_ROWS    = 3,
    parameter int TILE_COLUMNS = 5,
    parameter int DEPTH        = 3,
    parameter int REPEAT       = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    fixed_tile_replay_buffer_if.slave     bus
);
    localparam int NE = TILE_ROWS * TILE_COLUMNS;
    localparam int PW = cnt_w(DEPTH);
    localparam int RW = cnt_w(REPEAT);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT - 1);

    tile_replay_state_t state_q, state_d;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [RW-1:0] rep_cnt;
    logic wr_wrap, rd_wrap, rep_wrap, rep_inc;
    logic in_hs, out_hs;

    // Tile storage; never written while draining, so the output is stable.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH][NE];

    assign in_hs  = bus.data_in_valid && bus.data_in_ready;
    assign out_hs = bus.data_out_valid && bus.data_out_ready;

`ifdef TILE_REPLAY_PASSTHROUGH_EN
    // The forwarded fill stream is pass 0, so bump the pass count when it ends.
    assign rep_inc = rd_wrap || ((state_q == FILL) && wr_wrap);
`else
    assign rep_inc = rd_wrap;
`endif

    tile_wrap_counter #(.N(DEPTH)) u_wr (
        .clk(clk), .rst(rst), .inc_i(in_hs), .clr_i(1'b0),
        .cnt_o(wr_ptr), .wrap_o(wr_wrap)
    );

    tile_wrap_counter #(.N(DEPTH)) u_rd (
        .clk(clk), .rst(rst), .inc_i(out_hs && (state_q == DRAIN)), .clr_i(1'b0),
        .cnt_o(rd_ptr), .wrap_o(rd_wrap)
    );

    tile_wrap_counter #(.N(REPEAT)) u_rep (
        .clk(clk), .rst(rst), .inc_i(rep_inc), .clr_i(1'b0),
        .cnt_o(rep_cnt), .wrap_o(rep_wrap)
    );

    // FILL -> DRAIN on the last captured tile, DRAIN -> FILL on the last replayed tile.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: begin
                if (wr_wrap) begin
`ifdef TILE_REPLAY_PASSTHROUGH_EN
                    // With a single pass the forwarded stream was everything.
                    state_d = rep_wrap ? FILL : DRAIN;
`else
                    state_d = DRAIN;
`endif
                end
            end
            default: if (rep_wrap) state_d = FILL;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FILL;
        else     state_q <= state_d;
    end

    // Capture accepted tiles; storage carries no reset.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            for (int k = 0; k < NE; k++) mem_q[wr_ptr][k] <= bus.data_in[k];
        end
    end

    // Handshake outputs; reset forces everything quiet through state and rst.
    always_comb begin
        bus.data_in_ready  = 1'b0;
        bus.data_out_valid = 1'b0;
        bus.data_out_last  = 1'b0;
        for (int k = 0; k < NE; k++) bus.data_out[k] = mem_q[rd_ptr][k];
        if (state_q == FILL) begin
`ifdef TILE_REPLAY_PASSTHROUGH_EN
            bus.data_in_ready  = bus.data_out_ready && !rst;
            bus.data_out_valid = bus.data_in_valid && !rst;
            bus.data_out_last  = bus.data_in_valid && !rst &&
                                 (wr_ptr == PTR_LAST) && (rep_cnt == REP_LAST);
            for (int k = 0; k < NE; k++) bus.data_out[k] = bus.data_in[k];
`else
            bus.data_in_ready  = !rst;
`endif
        end else begin
            bus.data_out_valid = 1'b1;
            bus.data_out_last  = (rd_ptr == PTR_LAST) && (rep_cnt == REP_LAST);
        end
    end
endmodule

// File: tb/tb_fixed_tile_replay_buffer.sv
// Scoreboard bench: dut0 is DEPTH=3/REPEAT=2, dut1 is DEPTH=1/REPEAT=1.
module tb_fixed_tile_replay_buffer;
    import fixed_tile_pkg::*;

    localparam int DW = 16;
    localparam int NE = 15;
`ifdef TILE_REPLAY_PASSTHROUGH_EN
    localparam int PT = 1;
`else
    localparam int PT = 0;
`endif

    typedef struct packed {
        logic [15:0] e0;
        logic [15:0] en;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fixed_tile_replay_buffer_if #(.DATA_WIDTH(DW), .N_ELEM(NE)) b0 ();
    fixed_tile_replay_buffer_if #(.DATA_WIDTH(DW), .N_ELEM(NE)) b1 ();

    fixed_tile_replay_buffer #(.DATA_WIDTH(DW), .TILE_ROWS(3), .TILE_COLUMNS(5),
                               .DEPTH(3), .REPEAT(2)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    fixed_tile_replay_buffer #(.DATA_WIDTH(DW), .TILE_ROWS(3), .TILE_COLUMNS(5),
                               .DEPTH(1), .REPEAT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    exp_t        q0[$], q1[$];
    logic [15:0] cap0[$], cap1[$];
    int n_cmp = 0, n_err = 0;
    int hs0 = 0, hs1 = 0;
    logic        stall [2];
    logic [15:0] held  [2];
    logic        held_last [2];

    function automatic logic [15:0] el(input logic [15:0] b, input int k);
        return b + 16'(k * 256);
    endfunction

    function automatic exp_t mk(input logic [15:0] b, input logic l);
        exp_t e;
        e.e0 = b; e.en = el(b, NE - 1); e.last = l;
        return e;
    endfunction

    function automatic int qsize(input int idx);
        return (idx == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic rdy(input int idx);
        return (idx == 0) ? b0.data_in_ready : b1.data_in_ready;
    endfunction

    task automatic push_exp(input int idx, input exp_t e);
        if (idx == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    // Reference model + output checker, evaluated once per cycle away from the edge.
    task automatic mon(input int idx, input logic iv, input logic ir, input logic [15:0] i0,
                       input logic ov, input logic ordy, input logic ol,
                       input logic [15:0] o0, input logic [15:0] on);
        int d = (idx == 0) ? 3 : 1;
        int r = (idx == 0) ? 2 : 1;
        logic [15:0] blk[$];
        exp_t e;
        if (rst) begin
            stall[idx] = 1'b0;
            return;
        end
        if (iv && ir) begin
            if (idx == 0) begin cap0.push_back(i0); blk = cap0; end
            else          begin cap1.push_back(i0); blk = cap1; end
            if (PT == 1) push_exp(idx, mk(i0, (r == 1) && (blk.size() == d)));
            if (blk.size() == d) begin
                for (int p = PT; p < r; p++)
                    for (int t = 0; t < d; t++)
                        push_exp(idx, mk(blk[t], (p == r - 1) && (t == d - 1)));
                if (idx == 0) cap0.delete(); else cap1.delete();
            end
        end
        if (stall[idx]) begin
            n_cmp++;
            if (ov !== 1'b1 || o0 !== held[idx] || ol !== held_last[idx]) begin
                n_err++;
                $display("FAIL stall_hold dut%0d: got valid=%b data=%h last=%b, need valid=1 data=%h last=%b",
                         idx, ov, o0, ol, held[idx], held_last[idx]);
            end
        end
        stall[idx] = ov && !ordy;
        held[idx] = o0;
        held_last[idx] = ol;
        if (ov && ordy) begin
            n_cmp++;
            if (idx == 0) hs0++; else hs1++;
            if (qsize(idx) == 0) begin
                n_err++;
                $display("FAIL unexpected_out dut%0d: got data=%h last=%b, need no output", idx, o0, ol);
            end else begin
                if (idx == 0) e = q0.pop_front(); else e = q1.pop_front();
                if (o0 !== e.e0 || on !== e.en || ol !== e.last) begin
                    n_err++;
                    $display("FAIL out_tile dut%0d: got e0=%h en=%h last=%b, need e0=%h en=%h last=%b",
                             idx, o0, on, ol, e.e0, e.en, e.last);
                end
            end
        end
    endtask

    always @(negedge clk)
        mon(0, b0.data_in_valid, b0.data_in_ready, b0.data_in[0], b0.data_out_valid,
            b0.data_out_ready, b0.data_out_last, b0.data_out[0], b0.data_out[NE-1]);
    always @(negedge clk)
        mon(1, b1.data_in_valid, b1.data_in_ready, b1.data_in[0], b1.data_out_valid,
            b1.data_out_ready, b1.data_out_last, b1.data_out[0], b1.data_out[NE-1]);

    // Present one tile and hold it until accepted; returns cycles waited.
    task automatic send(input int idx, input logic [15:0] b, output int waited);
        waited = 0;
        for (int k = 0; k < NE; k++) begin
            if (idx == 0) b0.data_in[k] = el(b, k); else b1.data_in[k] = el(b, k);
        end
        if (idx == 0) b0.data_in_valid = 1'b1; else b1.data_in_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            waited++;
            if (rdy(idx) || waited >= 200) break;
        end
        if (!rdy(idx)) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout dut%0d: got no ready after %0d cycles, need ready", idx, waited);
        end
        @(posedge clk); #1;
        if (idx == 0) b0.data_in_valid = 1'b0; else b1.data_in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int idx);
        int n = 0;
        while (qsize(idx) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (qsize(idx) != 0) begin
            n_err++;
            $display("FAIL drain_timeout dut%0d: got %0d tiles pending, need 0", idx, qsize(idx));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({b0.data_in_ready, b0.data_out_valid, b0.data_out_last} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_out dut0: got rdy/vld/last=%b%b%b, need 000",
                     b0.data_in_ready, b0.data_out_valid, b0.data_out_last);
        end
        n_cmp++;
        if ({b1.data_in_ready, b1.data_out_valid, b1.data_out_last} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_out dut1: got rdy/vld/last=%b%b%b, need 000",
                     b1.data_in_ready, b1.data_out_valid, b1.data_out_last);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        b0.data_out_ready = 1'b1;
        b1.data_out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (b0.data_in_ready !== 1'b1 || b0.data_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_fill: got rdy=%b vld=%b, need rdy=1 vld=0",
                     b0.data_in_ready, b0.data_out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int w;
        int n = 3 * (2 - PT);
        send(0, 16'h0001, w);
        send(0, 16'h0002, w);
        send(0, 16'h0003, w);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            n_cmp++;
            if (b0.data_out_valid !== 1'b1 || b0.data_out_last !== (i == n - 1) ||
                b0.data_in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL basic_drain cycle %0d: got vld=%b last=%b rdy=%b, need vld=1 last=%b rdy=0",
                         i, b0.data_out_valid, b0.data_out_last, b0.data_in_ready, i == n - 1);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (b0.data_in_ready !== 1'b1 || b0.data_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_ready_return: got rdy=%b vld=%b, need rdy=1 vld=0",
                     b0.data_in_ready, b0.data_out_valid);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (q0.size() != 0) begin
            n_err++;
            $display("FAIL basic_sb_empty: got %0d pending, need 0", q0.size());
        end
    endtask

    task automatic test_backpressure;
        int w;
        logic done = 1'b0;
        hs0 = 0;
        fork
            begin
                send(0, 16'h0011, w);
                send(0, 16'h0012, w);
                send(0, 16'h0013, w);
                wait_drain(0);
                done = 1'b1;
            end
            begin
                int c = 0;
                while (!done && c < 400) begin
                    b0.data_out_ready = (c % 3 == 0);
                    @(posedge clk); #1;
                    c++;
                end
                b0.data_out_ready = 1'b1;
            end
        join
        n_cmp++;
        if (hs0 != 6) begin
            n_err++;
            $display("FAIL bp_handshakes: got %0d, need 6", hs0);
        end
    endtask

    task automatic test_hold_in_drain;
        int w;
        send(0, 16'h0021, w);
        send(0, 16'h0022, w);
        send(0, 16'h0023, w);
        send(0, 16'h0024, w);
        n_cmp++;
        if (w != 3 * (2 - PT) + 1) begin
            n_err++;
            $display("FAIL hold_wait: got accepted after %0d cycles, need %0d", w, 3 * (2 - PT) + 1);
        end
        send(0, 16'h0025, w);
        send(0, 16'h0026, w);
        wait_drain(0);
    endtask

    task automatic test_reset_mid;
        int w;
        send(0, 16'h0031, w);
        send(0, 16'h0032, w);
        send(0, 16'h0033, w);
        repeat ((PT == 1) ? 1 : 4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (b0.data_out_valid !== 1'b0 || b0.data_out_last !== 1'b0 || b0.data_in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: got vld=%b last=%b rdy=%b, need 000",
                     b0.data_out_valid, b0.data_out_last, b0.data_in_ready);
        end
        q0.delete(); cap0.delete(); q1.delete(); cap1.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (b0.data_in_ready !== 1'b1 || b0.data_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_fill: got rdy=%b vld=%b, need rdy=1 vld=0",
                     b0.data_in_ready, b0.data_out_valid);
        end
        @(posedge clk); #1;
        send(0, 16'h0041, w);
        send(0, 16'h0042, w);
        send(0, 16'h0043, w);
        wait_drain(0);
    endtask

    task automatic test_depth1;
        int w;
        logic ev = (PT == 0);
        send(1, 16'h0051, w);
        @(negedge clk);
        n_cmp++;
        if (b1.data_out_valid !== ev || b1.data_out_last !== ev || b1.data_in_ready !== !ev) begin
            n_err++;
            $display("FAIL d1_single: got vld=%b last=%b rdy=%b, need vld=%b last=%b rdy=%b",
                     b1.data_out_valid, b1.data_out_last, b1.data_in_ready, ev, ev, !ev);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            send(1, 16'(16'h0060 + i), w);
            if (i > 0) begin
                n_cmp++;
                if (w != 2 - PT) begin
                    n_err++;
                    $display("FAIL d1_rate tile %0d: got %0d cycles, need %0d", i, w, 2 - PT);
                end
            end
        end
        wait_drain(1);
    endtask

    initial begin
        rst = 1'b1;
        stall[0] = 1'b0; stall[1] = 1'b0;
        b0.data_in_valid = 1'b0; b0.data_out_ready = 1'b0;
        b1.data_in_valid = 1'b0; b1.data_out_ready = 1'b0;
        for (int k = 0; k < NE; k++) begin
            b0.data_in[k] = '0;
            b1.data_in[k] = '0;
        end
        test_reset;
        test_basic;
        test_backpressure;
        test_hold_in_drain;
        test_reset_mid;
        test_depth1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
